// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared IF/ID assembler state codes and class-field constants
package pipe_pkg;

    localparam int CLS_W = 3;
    localparam logic [CLS_W-1:0] IMM_CLASS_DEF = 3'b101;

    typedef logic [0:0] state_t;
    localparam state_t ST_OPC = 1'b0;
    localparam state_t ST_IMM = 1'b1;

endpackage

// File: rtl/if_id_perf_cnt.sv
// rtl/if_id_perf_cnt.sv - saturating bubble/flush event counter pair
module if_id_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bubble,
    input  logic        i_flush,
    output logic [15:0] o_bubbles,
    output logic [15:0] o_flushes
);

    logic [15:0] r_bubbles;
    logic [15:0] r_flushes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubbles <= 16'h0000;
            r_flushes <= 16'h0000;
        end else begin
            if (i_bubble && (r_bubbles != 16'hFFFF))
                r_bubbles <= r_bubbles + 16'd1;
            if (i_flush && (r_flushes != 16'hFFFF))
                r_flushes <= r_flushes + 16'd1;
        end
    end

    assign o_bubbles = r_bubbles;
    assign o_flushes = r_flushes;

endmodule

// File: rtl/if_id_assembler.sv
// rtl/if_id_assembler.sv - IF/ID register pairing immediate-class opcodes with their trailing word (IFID_PERF_CNT_EN adds perf counters)
module if_id_assembler
    import pipe_pkg::*;
#(
    parameter int                OPC_HI    = 15,
    parameter logic [CLS_W-1:0]  IMM_CLASS = IMM_CLASS_DEF,
    parameter int                PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [15:0]     in_word,
    input  logic [PC_W-1:0] in_pc,
    output logic            in_ready,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [15:0]     out_instr,
    output logic [15:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_has_imm
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0]     perf_bubbles,
    output logic [15:0]     perf_flushes
`endif
);

    state_t            r_state;
    logic [15:0]       r_hold_opc;
    logic [PC_W-1:0]   r_hold_pc;
    logic              r_out_valid;
    logic [15:0]       r_out_instr;
    logic [15:0]       r_out_imm;
    logic [PC_W-1:0]   r_out_pc;
    logic              r_out_has_imm;

    logic              w_accept;
    logic              w_two_word;
    logic              w_emit;
    logic [CLS_W-1:0]  w_cls;

    assign in_ready   = ~stall & ~flush;
    assign w_accept   = in_valid & in_ready;
    assign w_cls      = in_word[OPC_HI -: CLS_W];
    // Immediate words are never class-decoded, so the class test only matters in ST_OPC.
    assign w_two_word = (w_cls == IMM_CLASS);
    assign w_emit     = w_accept & ((r_state == ST_IMM) | ~w_two_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_OPC;
            r_hold_opc    <= 16'h0000;
            r_hold_pc     <= '0;
            r_out_valid   <= 1'b0;
            r_out_instr   <= 16'h0000;
            r_out_imm     <= 16'h0000;
            r_out_pc      <= '0;
            r_out_has_imm <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_OPC;
            r_out_valid <= 1'b0;
        end else if (!stall) begin
            r_out_valid <= w_emit;
            if (w_accept) begin
                if (r_state == ST_IMM) begin
                    r_out_instr   <= r_hold_opc;
                    r_out_imm     <= in_word;
                    r_out_pc      <= r_hold_pc;
                    r_out_has_imm <= 1'b1;
                    r_state       <= ST_OPC;
                end else if (w_two_word) begin
                    r_hold_opc <= in_word;
                    r_hold_pc  <= in_pc;
                    r_state    <= ST_IMM;
                end else begin
                    r_out_instr   <= in_word;
                    r_out_imm     <= 16'h0000;
                    r_out_pc      <= in_pc;
                    r_out_has_imm <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_imm     = r_out_imm;
    assign out_pc      = r_out_pc;
    assign out_has_imm = r_out_has_imm;

`ifdef IFID_PERF_CNT_EN
    logic w_bubble;
    assign w_bubble = ~stall & ~flush & ~w_emit;

    if_id_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_bubble  (w_bubble),
        .i_flush   (flush),
        .o_bubbles (perf_bubbles),
        .o_flushes (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_if_id_assembler.sv
// tb/tb_if_id_assembler.sv - directed self-checking bench for if_id_assembler
module tb_if_id_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_word;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic [31:0] out_pc;
    logic        out_has_imm;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] perf_bubbles;
    logic [15:0] perf_flushes;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    if_id_assembler dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_has_imm (out_has_imm)
`ifdef IFID_PERF_CNT_EN
        ,
        .perf_bubbles(perf_bubbles),
        .perf_flushes(perf_flushes)
`endif
    );

    // Drive one cycle of stimulus, take the edge, then settle 1ns past it.
    task automatic step(input logic v, input logic [15:0] w, input logic [31:0] pc,
                        input logic st, input logic fl);
        in_valid = v; in_word = w; in_pc = pc; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_word = 16'h0; in_pc = 32'h0; stall = 1'b0; flush = 1'b0;
        step(1'b1, 16'h2A01, 32'h10, 1'b0, 1'b0);
        step(1'b1, 16'h2A01, 32'h10, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_instr !== 16'h0 || out_imm !== 16'h0 || out_pc !== 32'h0 || out_has_imm !== 1'b0)
            $display("FAIL reset_data got %h %h %h %b want 0 0 0 0", out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        step(1'b1, 16'h2A01, 32'h10, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'h2A01 || out_imm !== 16'h0 || out_pc !== 32'h10 || out_has_imm !== 1'b0)
            $display("FAIL single got v=%b %h %h %h %b want 1 2a01 0000 10 0", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        step(1'b1, 16'h2A02, 32'h12, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'h2A02 || out_pc !== 32'h12)
            $display("FAIL b2b_0 got v=%b %h %h want 1 2a02 12", out_valid, out_instr, out_pc); else pass_cnt++;
        step(1'b1, 16'hE003, 32'h14, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'hE003 || out_pc !== 32'h14 || out_has_imm !== 1'b0)
            $display("FAIL b2b_1 got v=%b %h %h %b want 1 e003 14 0", out_valid, out_instr, out_pc, out_has_imm); else pass_cnt++;
    endtask

    task automatic test_pair();
        step(1'b1, 16'hA403, 32'h20, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL pair_bubble got %0b want 0", out_valid); else pass_cnt++;
        step(1'b1, 16'h1234, 32'h22, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'hA403 || out_imm !== 16'h1234 || out_pc !== 32'h20 || out_has_imm !== 1'b1)
            $display("FAIL pair got v=%b %h %h %h %b want 1 a403 1234 20 1", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
        // An immediate that looks like an imm-class opcode must not be decoded.
        step(1'b1, 16'hB000, 32'h24, 1'b0, 1'b0);
        step(1'b1, 16'hA0A0, 32'h26, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'hB000 || out_imm !== 16'hA0A0 || out_pc !== 32'h24)
            $display("FAIL pair_imm_nodecode got v=%b %h %h %h want 1 b000 a0a0 24", out_valid, out_instr, out_imm, out_pc); else pass_cnt++;
    endtask

    task automatic test_stall();
        step(1'b1, 16'h2A07, 32'h2E, 1'b0, 1'b0);
        step(1'b1, 16'h7777, 32'h30, 1'b1, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'h2A07 || out_pc !== 32'h2E)
            $display("FAIL stall_hold_valid got v=%b %h %h want 1 2a07 2e", out_valid, out_instr, out_pc); else pass_cnt++;
        step(1'b1, 16'hA403, 32'h30, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_word = 16'h1234; in_pc = 32'h32; stall = 1'b1; flush = 1'b0;
            #1;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_ready[%0d] got %0b want 0", i, in_ready); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (out_valid !== 1'b0 || out_instr !== 16'h2A07 || out_pc !== 32'h2E)
                $display("FAIL stall_frozen[%0d] got v=%b %h %h want 0 2a07 2e", i, out_valid, out_instr, out_pc); else pass_cnt++;
        end
        step(1'b1, 16'h1234, 32'h32, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'hA403 || out_imm !== 16'h1234 || out_pc !== 32'h30 || out_has_imm !== 1'b1)
            $display("FAIL stall_release got v=%b %h %h %h %b want 1 a403 1234 30 1", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
    endtask

    task automatic test_flush();
        step(1'b1, 16'hA403, 32'h40, 1'b0, 1'b0);
        in_valid = 1'b1; in_word = 16'h5555; in_pc = 32'h42; stall = 1'b0; flush = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %0b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else pass_cnt++;
        step(1'b1, 16'h2B00, 32'h44, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'h2B00 || out_imm !== 16'h0 || out_pc !== 32'h44 || out_has_imm !== 1'b0)
            $display("FAIL flush_next got v=%b %h %h %h %b want 1 2b00 0000 44 0", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
        // Flush beats stall and kills a valid instruction.
        step(1'b1, 16'h5555, 32'h46, 1'b1, 1'b1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_over_stall got %0b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_gap();
        step(1'b1, 16'hA403, 32'h50, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'hFFFF, 32'h52, 1'b0, 1'b0);
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL gap_valid[%0d] got %0b want 0", i, out_valid); else pass_cnt++;
        end
        step(1'b1, 16'hBEEF, 32'h56, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'hA403 || out_imm !== 16'hBEEF || out_pc !== 32'h50 || out_has_imm !== 1'b1)
            $display("FAIL gap_imm got v=%b %h %h %h %b want 1 a403 beef 50 1", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        step(1'b1, 16'h2A05, 32'h5E, 1'b0, 1'b0);
        step(1'b1, 16'hA403, 32'h60, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || out_instr !== 16'h0 || out_imm !== 16'h0 || out_pc !== 32'h0 || out_has_imm !== 1'b0)
            $display("FAIL async_clear got v=%b %h %h %h %b want all 0", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
        #1 rst = 1'b0;
        step(1'b1, 16'h2A01, 32'h64, 1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out_instr !== 16'h2A01 || out_imm !== 16'h0 || out_pc !== 32'h64 || out_has_imm !== 1'b0)
            $display("FAIL async_after got v=%b %h %h %h %b want 1 2a01 0000 64 0", out_valid, out_instr, out_imm, out_pc, out_has_imm); else pass_cnt++;
`ifdef IFID_PERF_CNT_EN
        total_cnt++; if (perf_bubbles !== 16'd0 || perf_flushes !== 16'd0)
            $display("FAIL perf_after_reset got %0d %0d want 0 0", perf_bubbles, perf_flushes); else pass_cnt++;
        step(1'b1, 16'h1111, 32'h66, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 32'h68, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 32'h6A, 1'b1, 1'b0);
        total_cnt++; if (perf_bubbles !== 16'd1 || perf_flushes !== 16'd1)
            $display("FAIL perf_counts got %0d %0d want 1 1", perf_bubbles, perf_flushes); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_pair();
        test_stall();
        test_flush();
        test_gap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/if_id_assembler.md
Name: if_id_assembler

Overview:
- Decode-side receiver of the fetch stage's instruction stream. It sits in the IF/ID boundary, replacing the bare pipeline register.
- Accepts 16-bit instruction-memory words one per cycle with their PC.
- Pairs every immediate-class opcode word with the following word as its 16-bit immediate.
- Presents complete instructions (opcode, immediate, PC) to decode, with stall hold and flush kill.

Parameters:
- OPC_HI, 15, MSB of the 3-bit instruction class field.
- IMM_CLASS, 3'b101, class value whose instructions carry a trailing immediate word.
- PC_W, 32, PC width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  fetch presents a word this cycle.
- in_word  input  16  instruction-memory word.
- in_pc  input  PC_W  address of in_word.
- in_ready  output  1  word is consumed this cycle when in_valid & in_ready.
- stall  input  1  hazard unit hold for ID.
- flush  input  1  branch/jump kill.
- out_valid  output  1  out_* hold a complete instruction.
- out_instr  output  16  opcode word.
- out_imm  output  16  immediate word; 16'h0000 for single-word instructions.
- out_pc  output  PC_W  PC of the opcode word.
- out_has_imm  output  1  instruction is two-word.

Behaviour:
- Reset: all outputs 0; state ST_OPC; captured opcode/PC registers 0. rst is asynchronous; assertion mid-pair discards the half-built instruction.
- in_ready = ~stall & ~flush (combinational).
- Class test: cls = in_word[OPC_HI:OPC_HI-2]; two-word when cls == IMM_CLASS.
- Priority per edge: flush > stall > normal.
- Flush: state goes to ST_OPC; out_valid goes to 0; any pending opcode is dropped; the input word that cycle is ignored.
- Stall (no flush): all registers hold; out_* stable; nothing consumed.
- ST_OPC, word accepted, single-word:
  - out_valid=1, out_instr=in_word, out_imm=0, out_pc=in_pc, out_has_imm=0.
  - Stay in ST_OPC. Latency 1 cycle.
- ST_OPC, word accepted, two-word:
  - Latch in_word and in_pc into hold registers.
  - out_valid=0 (bubble); go to ST_IMM.
- ST_IMM, word accepted:
  - out_valid=1, out_instr=held opcode, out_imm=in_word, out_pc=held PC, out_has_imm=1.
  - Go to ST_OPC. The immediate word is never class-decoded.
- No word accepted (in_valid=0, no stall/flush): out_valid=0 next edge; state and held opcode unchanged, so ST_IMM waits indefinitely for the immediate.
- Back-to-back single-word instructions: one per cycle, no bubbles.
- out_* data fields keep their last values when out_valid=0. Only out_valid is meaningful to decode.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- Defined: adds output perf_bubbles[15:0] and output perf_flushes[15:0].
  - perf_bubbles increments on each edge where out_valid becomes/stays 0 without stall or flush.
  - perf_flushes increments on each flush edge.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: no counters and no ports; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (ST_OPC=1'b0, ST_IMM=1'b1);
  - the IMM_CLASS default and the class-field width constant (3).
- One natural sub-module, if_id_perf_cnt: saturating counter pair, instantiated only under IFID_PERF_CNT_EN.

Test Plan:
- Reset then single word: rst pulse; in_word=16'h2A01, in_pc=0x10 -> next edge out_valid=1, out_instr=2A01, out_imm=0, out_pc=0x10, out_has_imm=0.
- Two-word pair:
  - Cycle 1: in_word=16'hA403 (class 101), pc=0x20. Cycle 2: in_word=16'h1234, pc=0x22.
  - Edge 1: out_valid=0. Edge 2: out_valid=1, instr=A403, imm=1234, pc=0x20, has_imm=1.
- Stall mid-pair: A403 accepted, then stall=1 for 3 cycles with in_word=1234 -> in_ready=0, outputs frozen, state ST_IMM. Stall drops -> 1234 accepted as immediate.
- Flush mid-pair: A403 accepted, then flush=1 with in_word=5555 -> out_valid=0, state ST_OPC. Next word 16'h2B00 -> emitted as single-word instruction.
- Gap in ST_IMM: A403, then in_valid=0 for 2 cycles, then 0xBEEF -> out_valid=0 during the gap, then imm=BEEF, pc kept.
- Async reset mid-pair: rst asserted between edges after A403 -> outputs clear immediately. After release, 16'h2A01 is treated as an opcode word.
